// File: rtl/conv3x3_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | conv3x3_pkg: shared config address map, mode bits, default sizes   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package conv3x3_pkg;

  localparam int DEF_DW   = 20;
  localparam int DEF_FRAC = 16;
  localparam int DEF_NCH  = 2;

  localparam logic [3:0] ADDR_W_LAST = 4'd8;
  localparam logic [3:0] ADDR_BIAS   = 4'd9;
  localparam logic [3:0] ADDR_MODE   = 4'd10;

  localparam int MODE_RELU_BIT = 0;
  localparam int MODE_SAT_BIT  = 1;
  localparam logic [1:0] MODE_RESET = 2'b01;

endpackage
`default_nettype wire

// File: rtl/conv3x3_channel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | conv3x3_channel: per-channel coefficients and S1-S3 datapath       |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module conv3x3_channel
  import conv3x3_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int FRAC = DEF_FRAC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_en,
  input  logic [3:0]      cfg_addr,
  input  logic [DW-1:0]   cfg_wdata,
  input  logic            load_s1,
  input  logic            load_s2,
  input  logic            load_out,
  input  logic [9*DW-1:0] win,
  output logic [DW-1:0]   result
);

  localparam int PW = 2*DW - FRAC + 1;
  localparam int SW = PW + 4;
  localparam logic signed [2*DW-1:0] HALF = {{(2*DW-1){1'b0}}, 1'b1} << (FRAC-1);
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [DW-1:0] weight [9];
  logic signed [DW-1:0] bias;
  logic [1:0]           mode;

  logic [PW-1:0]        prod_rnd [9];
  logic [PW-1:0]        s1_p [9];
  logic signed [SW-1:0] psum_a, psum_b;
  logic [PW-1:0]        s2_p7, s2_p8;
  logic signed [SW-1:0] total;
  logic [DW-1:0]        res_c;

  function automatic logic signed [SW-1:0] sx(input logic [PW-1:0] v);
    return SW'($signed(v));
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 9; k++) weight[k] <= '0;
      bias <= '0;
      mode <= MODE_RESET;
    end else if (cfg_en) begin
      for (int k = 0; k < 9; k++)
        if (cfg_addr == 4'(k)) weight[k] <= cfg_wdata;
      if (cfg_addr == ADDR_BIAS) bias <= cfg_wdata;
      if (cfg_addr == ADDR_MODE) mode <= cfg_wdata[1:0];
    end
  end

  // Adding half an LSB before the arithmetic shift gives round-half-up
  generate
    for (genvar k = 0; k < 9; k++) begin : g_tap
      logic signed [2*DW-1:0] tap_ext, w_ext;
      assign tap_ext     = (2*DW)'($signed(win[k*DW +: DW]));
      assign w_ext       = (2*DW)'(weight[k]);
      assign prod_rnd[k] = PW'((tap_ext * w_ext + HALF) >>> FRAC);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 9; k++) s1_p[k] <= '0;
      psum_a <= '0;
      psum_b <= '0;
      s2_p7  <= '0;
      s2_p8  <= '0;
      result <= '0;
    end else begin
      if (load_s1)
        for (int k = 0; k < 9; k++) s1_p[k] <= prod_rnd[k];
      if (load_s2) begin
        psum_a <= SW'(bias) + sx(s1_p[0]) + sx(s1_p[1]) + sx(s1_p[2]);
        psum_b <= sx(s1_p[3]) + sx(s1_p[4]) + sx(s1_p[5]) + sx(s1_p[6]);
        s2_p7  <= s1_p[7];
        s2_p8  <= s1_p[8];
      end
      if (load_out) result <= res_c;
    end
  end

  always_comb begin
    total = psum_a + psum_b + sx(s2_p7) + sx(s2_p8);
    res_c = total[DW-1:0];
    if (mode[MODE_SAT_BIT]) begin
      if (total > SAT_MAX)      res_c = SAT_MAX[DW-1:0];
      else if (total < SAT_MIN) res_c = SAT_MIN[DW-1:0];
    end
    if (mode[MODE_RELU_BIT] && res_c[DW-1]) res_c = '0;
  end

endmodule
`default_nettype wire

// File: rtl/conv3x3_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | conv3x3_engine: NCH-channel 3x3 convolution, 3-stage pipeline      |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module conv3x3_engine
  import conv3x3_pkg::*;
#(
  parameter  int DW   = DEF_DW,
  parameter  int FRAC = DEF_FRAC,
  parameter  int NCH  = DEF_NCH,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic [3:0]        cfg_addr,
  input  logic [DW-1:0]     cfg_wdata,
  output logic              cfg_busy,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [9*DW-1:0]   i_data,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [NCH*DW-1:0] o_data
);

  logic en, accept, cfg_ok;
  logic v1, v2;

  assign en       = !o_valid || o_ready;
  assign i_ready  = en && !cfg_we;
  assign accept   = i_valid && i_ready;
  assign cfg_busy = v1 || v2 || o_valid;
  assign cfg_ok   = cfg_we && !cfg_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      o_valid <= 1'b0;
    end else if (en) begin
      v1      <= accept;
      v2      <= v1;
      o_valid <= v2;
    end
  end

  // Out-of-range channel codes match no instance, so such writes are dropped
  generate
    for (genvar c = 0; c < NCH; c++) begin : g_ch
      conv3x3_channel #(.DW(DW), .FRAC(FRAC)) u_ch (
        .clk       (clk),
        .reset     (reset),
        .cfg_en    (cfg_ok && (cfg_ch == CHW'(c))),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .load_s1   (accept),
        .load_s2   (en && v1),
        .load_out  (en && v2),
        .win       (i_data),
        .result    (o_data[c*DW +: DW])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_conv3x3_engine: scoreboard bench for conv3x3_engine             |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_conv3x3_engine;

  localparam int DW = 20;
  localparam int FRAC = 16;
  localparam int NCH = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cfg_we = 1'b0;
  logic [0:0]        cfg_ch = '0;
  logic [3:0]        cfg_addr = '0;
  logic [DW-1:0]     cfg_wdata = '0;
  logic              cfg_busy;
  logic              i_valid = 1'b0;
  logic              i_ready;
  logic [9*DW-1:0]   i_data = '0;
  logic              o_valid;
  logic              o_ready = 1'b1;
  logic [NCH*DW-1:0] o_data;

  int checks = 0;
  int errors = 0;
  int outs = 0;

  logic [NCH*DW-1:0]    sb[$];
  logic signed [DW-1:0] mw[NCH][9];
  logic signed [DW-1:0] mb[NCH];
  logic [1:0]           mmode[NCH];

  always #5 clk = ~clk;

  conv3x3_engine #(.DW(DW), .FRAC(FRAC), .NCH(NCH)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_busy(cfg_busy),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data)
  );

  function automatic logic [NCH*DW-1:0] model(input logic [9*DW-1:0] w);
    logic [NCH*DW-1:0] r;
    r = '0;
    for (int c = 0; c < NCH; c++) begin
      longint acc, p, t, k1, res;
      logic signed [DW-1:0] tap;
      logic [DW-1:0] v;
      acc = longint'(mb[c]);
      for (int k = 0; k < 9; k++) begin
        tap = w[k*DW +: DW];
        t   = longint'(tap);
        k1  = longint'(mw[c][k]);
        p   = t * k1;
        acc = acc + (p >>> FRAC) + ((p >>> (FRAC-1)) & 64'sd1);
      end
      res = acc;
      if (mmode[c][1]) begin
        if (res > (64'sd1 <<< (DW-1)) - 1) res = (64'sd1 <<< (DW-1)) - 1;
        else if (res < -(64'sd1 <<< (DW-1))) res = -(64'sd1 <<< (DW-1));
      end
      v = res[DW-1:0];
      if (mmode[c][0] && v[DW-1]) v = '0;
      r[c*DW +: DW] = v;
    end
    return r;
  endfunction

  function automatic logic [9*DW-1:0] rand_win();
    logic [9*DW-1:0] w;
    for (int k = 0; k < 9; k++) w[k*DW +: DW] = DW'($urandom);
    return w;
  endfunction

  // Scoreboard: pop/compare on each output transfer, push on each accepted window
  always @(negedge clk) begin
    logic [NCH*DW-1:0] exp_d;
    if (!reset && o_valid && o_ready) begin
      outs++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got o_data=%h, required no output", o_data);
      end else begin
        exp_d = sb.pop_front();
        if (o_data !== exp_d) begin
          errors++;
          $display("FAIL sb_data: got o_data=%h, required %h", o_data, exp_d);
        end
      end
    end
    if (!reset && i_valid && i_ready) sb.push_back(model(i_data));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < 9; k++) mw[c][k] = '0;
      mb[c] = '0;
      mmode[c] = 2'b01;
    end
  endtask

  task automatic cfg_write(input int ch, input int addr, input logic [DW-1:0] d);
    cfg_we = 1'b1;
    cfg_ch = ch[0:0];
    cfg_addr = addr[3:0];
    cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
    if (addr < 9) mw[ch][addr] = d;
    else if (addr == 9) mb[ch] = d;
    else if (addr == 10) mmode[ch] = d[1:0];
  endtask

  task automatic send(input logic [9*DW-1:0] w, output bit ok);
    bit acc;
    ok = 1'b0;
    i_valid = 1'b1;
    i_data = w;
    for (int n = 0; n < 20 && !ok; n++) begin
      #1;
      acc = i_ready;
      @(posedge clk);
      #1;
      ok = acc;
    end
    i_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [NCH*DW-1:0] d, output int lat, output bit ok);
    ok = 1'b0;
    lat = 1;
    d = '0;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (o_valid) begin
        d = o_data;
        ok = 1'b1;
      end else begin
        tick();
        lat++;
      end
    end
    if (ok) tick();
  endtask

  function automatic logic [9*DW-1:0] tap0_win(input logic [DW-1:0] v);
    logic [9*DW-1:0] w;
    w = '0;
    w[DW-1:0] = v;
    return w;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid: got %b, required 0", o_valid); end
    checks++;
    if (o_data !== '0) begin errors++; $display("FAIL reset_o_data: got %h, required 0", o_data); end
    checks++;
    if (cfg_busy !== 1'b0) begin errors++; $display("FAIL reset_cfg_busy: got %b, required 0", cfg_busy); end
    checks++;
    if (i_ready !== 1'b1) begin errors++; $display("FAIL reset_i_ready: got %b, required 1", i_ready); end
    reset = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic test_unity();
    logic [NCH*DW-1:0] d;
    int lat;
    bit ok_in, ok_out;
    cfg_write(0, 0, 20'h10000);
    send(tap0_win(20'h18000), ok_in);
    wait_out(d, lat, ok_out);
    checks++;
    if (!ok_in || !ok_out || lat != 3) begin
      errors++;
      $display("FAIL unity_latency: got %0d cycles (in=%0b out=%0b), required 3", lat, ok_in, ok_out);
    end
    checks++;
    if (d[DW-1:0] !== 20'h18000) begin
      errors++;
      $display("FAIL unity_data: got ch0=%h, required 18000", d[DW-1:0]);
    end
  endtask

  task automatic test_round();
    logic [NCH*DW-1:0] d;
    int lat;
    bit ok_in, ok_out;
    cfg_write(1, 0, 20'h08000);
    send(tap0_win(20'h00001), ok_in);
    wait_out(d, lat, ok_out);
    checks++;
    if (!ok_in || !ok_out || d[2*DW-1:DW] !== 20'h00001) begin
      errors++;
      $display("FAIL round_up: got ch1=%h, required 00001", d[2*DW-1:DW]);
    end
    send(tap0_win(20'h00000), ok_in);
    wait_out(d, lat, ok_out);
    checks++;
    if (!ok_in || !ok_out || d[2*DW-1:DW] !== 20'h00000) begin
      errors++;
      $display("FAIL round_zero: got ch1=%h, required 00000", d[2*DW-1:DW]);
    end
  endtask

  task automatic test_bias_mode();
    logic [NCH*DW-1:0] d;
    int lat;
    bit ok_in, ok_out;
    cfg_write(0, 0, 20'h00000);
    cfg_write(0, 9, 20'hF0000);
    cfg_write(0, 11, 20'h00003);
    send('0, ok_in);
    wait_out(d, lat, ok_out);
    checks++;
    if (!ok_in || !ok_out || d[DW-1:0] !== 20'h00000) begin
      errors++;
      $display("FAIL bias_relu: got ch0=%h, required 00000", d[DW-1:0]);
    end
    cfg_write(0, 10, 20'h00000);
    send('0, ok_in);
    wait_out(d, lat, ok_out);
    checks++;
    if (!ok_in || !ok_out || d[DW-1:0] !== 20'hF0000) begin
      errors++;
      $display("FAIL bias_plain: got ch0=%h, required F0000", d[DW-1:0]);
    end
  endtask

  task automatic test_saturate();
    logic [NCH*DW-1:0] d;
    logic [9*DW-1:0] w;
    logic [DW-1:0] exp_v [3];
    logic [1:0] modes [3];
    int lat;
    bit ok_in, ok_out;
    modes[0] = 2'b10; exp_v[0] = 20'h7FFFF;
    modes[1] = 2'b00; exp_v[1] = 20'h90000;
    modes[2] = 2'b01; exp_v[2] = 20'h00000;
    for (int k = 0; k < 9; k++) begin
      cfg_write(0, k, 20'h70000);
      w[k*DW +: DW] = 20'h70000;
    end
    cfg_write(0, 9, 20'h00000);
    for (int m = 0; m < 3; m++) begin
      cfg_write(0, 10, {18'd0, modes[m]});
      send(w, ok_in);
      wait_out(d, lat, ok_out);
      checks++;
      if (!ok_in || !ok_out || d[DW-1:0] !== exp_v[m]) begin
        errors++;
        $display("FAIL sat_mode%0d: got ch0=%h, required %h", modes[m], d[DW-1:0], exp_v[m]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9*DW-1:0] wins [8];
    logic [NCH*DW-1:0] d;
    int sent, outs0, lat;
    bit acc, dropped, busy_seen, ok_in, ok_out;
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < 9; k++) cfg_write(c, k, DW'($urandom));
      cfg_write(c, 9, DW'($urandom));
      cfg_write(c, 10, DW'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 8; i++) wins[i] = rand_win();
    sent = 0;
    outs0 = outs;
    dropped = 1'b0;
    busy_seen = 1'b0;
    for (int cyc = 0; cyc < 80 && (sent < 8 || outs - outs0 < 8); cyc++) begin
      o_ready = !(cyc >= 4 && cyc <= 8);
      i_valid = (sent < 8);
      i_data = (sent < 8) ? wins[sent] : '0;
      cfg_we = (cyc == 6);
      cfg_ch = 1'b0;
      cfg_addr = 4'd0;
      cfg_wdata = 20'h12345;
      #1;
      if (cyc == 6) busy_seen = cfg_busy;
      if (i_valid && !i_ready) dropped = 1'b1;
      acc = i_valid && i_ready;
      @(posedge clk);
      #1;
      if (acc) sent++;
    end
    cfg_we = 1'b0;
    i_valid = 1'b0;
    o_ready = 1'b1;
    checks++;
    if (!dropped) begin errors++; $display("FAIL b2b_backpressure: got i_ready never low, required a drop"); end
    checks++;
    if (outs - outs0 != 8) begin errors++; $display("FAIL b2b_count: got %0d outputs, required 8", outs - outs0); end
    checks++;
    if (busy_seen !== 1'b1) begin errors++; $display("FAIL b2b_busy: got cfg_busy=%b, required 1", busy_seen); end
    send(rand_win(), ok_in);
    wait_out(d, lat, ok_out);
    checks++;
    if (!ok_in || !ok_out || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: got in=%0b out=%0b pending=%0d, required 1 1 0", ok_in, ok_out, sb.size());
    end
  endtask

  task automatic test_reset_midstream();
    logic [NCH*DW-1:0] d;
    logic [9*DW-1:0] w;
    int lat;
    bit ok_in, ok_out;
    for (int k = 0; k < 9; k++) begin
      cfg_write(0, k, 20'h10000);
      w[k*DW +: DW] = 20'h10000;
    end
    cfg_write(1, 0, 20'h10000);
    cfg_write(0, 10, 20'h00002);
    o_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1;
      i_data = w;
      tick();
    end
    i_valid = 1'b0;
    reset = 1'b1;
    sb.delete();
    model_reset();
    tick();
    reset = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || cfg_busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_flags: got o_valid=%b cfg_busy=%b, required 0 0", o_valid, cfg_busy);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (o_valid !== 1'b0) begin errors++; $display("FAIL midreset_stale: got o_valid=%b at cycle %0d, required 0", o_valid, i); end
    end
    send(w, ok_in);
    wait_out(d, lat, ok_out);
    checks++;
    if (!ok_in || !ok_out || d !== '0) begin
      errors++;
      $display("FAIL midreset_weights: got o_data=%h, required 0", d);
    end
    cfg_write(0, 9, 20'hF0000);
    send('0, ok_in);
    wait_out(d, lat, ok_out);
    checks++;
    if (!ok_in || !ok_out || d[DW-1:0] !== 20'h00000) begin
      errors++;
      $display("FAIL midreset_relu: got ch0=%h, required 00000", d[DW-1:0]);
    end
    cfg_write(0, 10, 20'h00000);
    send('0, ok_in);
    wait_out(d, lat, ok_out);
    checks++;
    if (!ok_in || !ok_out || d[DW-1:0] !== 20'hF0000) begin
      errors++;
      $display("FAIL midreset_bias: got ch0=%h, required F0000", d[DW-1:0]);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_unity();
    test_round();
    test_bias_mode();
    test_saturate();
    test_back_to_back();
    test_reset_midstream();
    tick();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending, required 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000, required finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
